// File: rtl/mwadd_pkg.sv
// rtl/mwadd_pkg.sv - shared FSM type, counter-width helper and reset values for multi_word_add_seq
package mwadd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Chunk counter width; a single-chunk build still needs one bit.
  function automatic int cnt_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

  localparam state_t RST_STATE     = IDLE;
  localparam logic   RST_IN_READY  = 1'b1;
  localparam logic   RST_OUT_VALID = 1'b0;
  localparam logic   RST_BUSY      = 1'b0;
  localparam logic   RST_COUT      = 1'b0;

endpackage

// File: rtl/multi_word_add_seq_if.sv
// rtl/multi_word_add_seq_if.sv - request/result handshake bundle (sub port present when MWADD_SUB_EN is defined)
interface multi_word_add_seq_if #(
  parameter int N     = 4,
  parameter int WORDS = 4
);
  localparam int W = N * WORDS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
`ifdef MWADD_SUB_EN
  logic         sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

`ifdef MWADD_SUB_EN
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
`else
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
`endif

endinterface

// File: rtl/n_bit_adder.sv
// rtl/n_bit_adder.sv - N-bit ripple-carry adder shared by the chunk sequencer
module n_bit_adder #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] c;

  // Chain of full-adder cells, carry rippling from bit 0 upward.
  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < N; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[N];
  end

endmodule

// File: rtl/multi_word_add_seq.sv
// rtl/multi_word_add_seq.sv - wide add over WORDS cycles on one N-bit adder (subtract option: MWADD_SUB_EN)
module multi_word_add_seq
  import mwadd_pkg::*;
#(
  parameter int N     = 4,
  parameter int WORDS = 4
) (
  input logic                clk,
  input logic                rst,
  multi_word_add_seq_if.slave bus
);

  localparam int W  = N * WORDS;
  localparam int CW = cnt_width(WORDS);
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  state_t        state;
  logic [W-1:0]  a_sh;
  logic [W-1:0]  b_sh;
  logic [W-1:0]  res;
  logic [W-1:0]  sum_r;
  logic [CW-1:0] cnt;
  logic          carry;
  logic          cout_r;
  logic          in_ready_r;
  logic          out_valid_r;
  logic          busy_r;
`ifdef MWADD_SUB_EN
  logic          sub_r;
`endif

  logic [N-1:0]  add_a;
  logic [N-1:0]  add_b;
  logic [N-1:0]  add_sum;
  logic          add_cout;
  logic [W-1:0]  res_next;

  assign add_a = a_sh[N-1:0];
`ifdef MWADD_SUB_EN
  // Two's-complement subtract: invert B here, the +1 comes from the seeded carry.
  assign add_b = b_sh[N-1:0] ^ {N{sub_r}};
`else
  assign add_b = b_sh[N-1:0];
`endif

  n_bit_adder #(.N(N)) u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // New chunk enters the result from the top so chunk 0 ends up at the LSBs.
  generate
    if (WORDS == 1) begin : g_one
      assign res_next = add_sum;
    end else begin : g_multi
      assign res_next = {add_sum, res[W-1:N]};
    end
  endgenerate

  // Control FSM with operand shifters, carry, chunk counter and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RST_STATE;
      in_ready_r  <= RST_IN_READY;
      out_valid_r <= RST_OUT_VALID;
      busy_r      <= RST_BUSY;
      cout_r      <= RST_COUT;
      sum_r       <= '0;
      a_sh        <= '0;
      b_sh        <= '0;
      res         <= '0;
      carry       <= 1'b0;
      cnt         <= '0;
`ifdef MWADD_SUB_EN
      sub_r       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_r) begin
            a_sh       <= bus.a;
            b_sh       <= bus.b;
`ifdef MWADD_SUB_EN
            sub_r      <= bus.sub;
            carry      <= bus.sub ? 1'b1 : bus.cin;
`else
            carry      <= bus.cin;
`endif
            cnt        <= '0;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          res   <= res_next;
          carry <= add_cout;
          a_sh  <= a_sh >> N;
          b_sh  <= b_sh >> N;
          if (cnt == LAST) begin
            sum_r       <= res_next;
            cout_r      <= add_cout;
            out_valid_r <= 1'b1;
            state       <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;

endmodule

// File: tb/tb_multi_word_add_seq.sv
// tb/tb_multi_word_add_seq.sv - directed and golden-model bench for multi_word_add_seq (MWADD_SUB_EN adds subtract cases)
module tb_multi_word_add_seq;

  logic clk = 1'b0;
  logic rst;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  multi_word_add_seq_if #(.N(4), .WORDS(4)) bus4 ();
  multi_word_add_seq_if #(.N(4), .WORDS(1)) bus1 ();
  multi_word_add_seq_if #(.N(8), .WORDS(3)) bus8 ();

  multi_word_add_seq #(.N(4), .WORDS(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
  multi_word_add_seq #(.N(4), .WORDS(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  multi_word_add_seq #(.N(8), .WORDS(3)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));

  task automatic start4(input logic [15:0] a, input logic [15:0] b, input logic cin);
    @(negedge clk);
    bus4.a = a; bus4.b = b; bus4.cin = cin; bus4.in_valid = 1'b1;
    @(posedge clk);
    #1 bus4.in_valid = 1'b0;
  endtask

  task automatic wait4(output int lat);
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (bus4.out_valid) break;
    end
  endtask

  task automatic release4();
    @(negedge clk) bus4.out_ready = 1'b1;
    @(posedge clk);
    #1 bus4.out_ready = 1'b0;
  endtask

  task automatic op1(input logic [3:0] a, input logic [3:0] b, input logic cin,
                     output logic [4:0] res, output int lat);
    @(negedge clk);
    bus1.a = a; bus1.b = b; bus1.cin = cin; bus1.in_valid = 1'b1;
    @(posedge clk);
    #1 bus1.in_valid = 1'b0;
    lat = 0;
    while (lat < 10) begin
      @(posedge clk); #1;
      lat++;
      if (bus1.out_valid) break;
    end
    res = {bus1.cout, bus1.sum};
    @(negedge clk) bus1.out_ready = 1'b1;
    @(posedge clk);
    #1 bus1.out_ready = 1'b0;
  endtask

  task automatic op8(input logic [23:0] a, input logic [23:0] b, input logic cin,
                     output logic [24:0] res, output int lat);
    @(negedge clk);
    bus8.a = a; bus8.b = b; bus8.cin = cin; bus8.in_valid = 1'b1;
    @(posedge clk);
    #1 bus8.in_valid = 1'b0;
    lat = 0;
    while (lat < 10) begin
      @(posedge clk); #1;
      lat++;
      if (bus8.out_valid) break;
    end
    res = {bus8.cout, bus8.sum};
    @(negedge clk) bus8.out_ready = 1'b1;
    @(posedge clk);
    #1 bus8.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total_cnt++;
    if (bus4.in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", bus4.in_ready);
    else pass_cnt++;
    total_cnt++;
    if (bus4.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", bus4.out_valid);
    else pass_cnt++;
    total_cnt++;
    if (bus4.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus4.busy);
    else pass_cnt++;
    total_cnt++;
    if ({bus4.cout, bus4.sum} !== 17'h0) $display("FAIL reset_result got=%h exp=00000", {bus4.cout, bus4.sum});
    else pass_cnt++;
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_carry_ripple();
    int lat;
    start4(16'hFFFF, 16'h0001, 1'b0);
    wait4(lat);
    total_cnt++;
    if (lat !== 4) $display("FAIL ripple_latency got=%0d exp=4", lat);
    else pass_cnt++;
    total_cnt++;
    if ({bus4.cout, bus4.sum} !== 17'h10000) $display("FAIL ripple_result got=%h exp=10000", {bus4.cout, bus4.sum});
    else pass_cnt++;
    total_cnt++;
    if ({bus4.busy, bus4.in_ready} !== 2'b10) $display("FAIL ripple_busy_in_ready got=%b exp=10", {bus4.busy, bus4.in_ready});
    else pass_cnt++;
    release4();
    total_cnt++;
    if ({bus4.in_ready, bus4.out_valid, bus4.busy} !== 3'b100) $display("FAIL ripple_back_idle got=%b exp=100", {bus4.in_ready, bus4.out_valid, bus4.busy});
    else pass_cnt++;
    total_cnt++;
    if ({bus4.cout, bus4.sum} !== 17'h10000) $display("FAIL ripple_retained got=%h exp=10000", {bus4.cout, bus4.sum});
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int lat;
    start4(16'h1234, 16'h4321, 1'b1);
    wait4(lat);
    total_cnt++;
    if (lat !== 4) $display("FAIL bp_latency got=%0d exp=4", lat);
    else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      total_cnt++;
      if ({bus4.out_valid, bus4.in_ready, bus4.cout, bus4.sum} !== {2'b10, 17'h05556})
        $display("FAIL bp_hold cycle=%0d got=%b_%b_%h exp=1_0_05556", i, bus4.out_valid, bus4.in_ready, {bus4.cout, bus4.sum});
      else pass_cnt++;
      @(posedge clk); #1;
    end
    release4();
    total_cnt++;
    if ({bus4.in_ready, bus4.out_valid} !== 2'b10) $display("FAIL bp_release got=%b exp=10", {bus4.in_ready, bus4.out_valid});
    else pass_cnt++;
  endtask

  task automatic test_busy_rejection();
    int lat;
    start4(16'h1111, 16'h2222, 1'b0);
    @(negedge clk);
    bus4.a = 16'h0001; bus4.b = 16'h0001; bus4.in_valid = 1'b1;
    @(negedge clk) bus4.in_valid = 1'b0;
    wait4(lat);
    total_cnt++;
    if ({bus4.out_valid, bus4.cout, bus4.sum} !== {1'b1, 17'h03333}) $display("FAIL busy_first got=%b_%h exp=1_03333", bus4.out_valid, {bus4.cout, bus4.sum});
    else pass_cnt++;
    @(negedge clk) bus4.in_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total_cnt++;
    if ({bus4.out_valid, bus4.in_ready, bus4.sum} !== {2'b10, 16'h3333}) $display("FAIL busy_done_hold got=%b_%b_%h exp=1_0_3333", bus4.out_valid, bus4.in_ready, bus4.sum);
    else pass_cnt++;
    @(negedge clk) bus4.out_ready = 1'b1;
    @(posedge clk);
    #1 bus4.out_ready = 1'b0;
    total_cnt++;
    if ({bus4.out_valid, bus4.in_ready} !== 2'b01) $display("FAIL busy_idle got=%b exp=01", {bus4.out_valid, bus4.in_ready});
    else pass_cnt++;
    @(posedge clk);
    #1 bus4.in_valid = 1'b0;
    total_cnt++;
    if ({bus4.busy, bus4.in_ready} !== 2'b10) $display("FAIL busy_second_accept got=%b exp=10", {bus4.busy, bus4.in_ready});
    else pass_cnt++;
    wait4(lat);
    total_cnt++;
    if (lat !== 4 || {bus4.cout, bus4.sum} !== 17'h00002) $display("FAIL busy_second got=%0d_%h exp=4_00002", lat, {bus4.cout, bus4.sum});
    else pass_cnt++;
    release4();
  endtask

  task automatic test_reset_mid();
    int stale;
    start4(16'h00FF, 16'h0001, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    total_cnt++;
    if ({bus4.in_ready, bus4.out_valid, bus4.busy} !== 3'b100) $display("FAIL rstmid_ctrl got=%b exp=100", {bus4.in_ready, bus4.out_valid, bus4.busy});
    else pass_cnt++;
    total_cnt++;
    if ({bus4.cout, bus4.sum} !== 17'h0) $display("FAIL rstmid_result got=%h exp=00000", {bus4.cout, bus4.sum});
    else pass_cnt++;
    @(negedge clk) rst = 1'b0;
    stale = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus4.out_valid) stale++;
    end
    total_cnt++;
    if (stale !== 0) $display("FAIL rstmid_stale got=%0d exp=0", stale);
    else pass_cnt++;
  endtask

`ifdef MWADD_SUB_EN
  task automatic test_sub();
    int lat;
    bus4.sub = 1'b1;
    start4(16'h0005, 16'h0007, 1'b0);
    wait4(lat);
    total_cnt++;
    if ({bus4.cout, bus4.sum} !== 17'h0FFFE) $display("FAIL sub_borrow got=%h exp=0fffe", {bus4.cout, bus4.sum});
    else pass_cnt++;
    release4();
    start4(16'h0007, 16'h0005, 1'b0);
    wait4(lat);
    total_cnt++;
    if ({bus4.cout, bus4.sum} !== 17'h10002) $display("FAIL sub_noborrow got=%h exp=10002", {bus4.cout, bus4.sum});
    else pass_cnt++;
    release4();
    bus4.sub = 1'b0;
  endtask
`endif

  task automatic test_random();
    int lat;
    logic [15:0] ra, rb;
    logic        rc;
    logic [16:0] exp_r;
    for (int t = 0; t < 200; t++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom_range(0, 1));
      exp_r = {1'b0, ra} + {1'b0, rb} + {16'h0, rc};
      start4(ra, rb, rc);
      wait4(lat);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      total_cnt++;
      if (lat !== 4 || {bus4.out_valid, bus4.cout, bus4.sum} !== {1'b1, exp_r})
        $display("FAIL rand4 t=%0d a=%h b=%h cin=%b got=%0d_%b_%h exp=4_1_%h", t, ra, rb, rc, lat, bus4.out_valid, {bus4.cout, bus4.sum}, exp_r);
      else pass_cnt++;
      release4();
    end
  endtask

  task automatic test_words1();
    int lat;
    logic [4:0] got;
    logic [3:0] ra, rb;
    logic       rc;
    logic [4:0] exp_r;
    op1(4'hF, 4'h1, 1'b0, got, lat);
    total_cnt++;
    if (lat !== 1 || got !== 5'h10) $display("FAIL w1_wrap got=%0d_%h exp=1_10", lat, got);
    else pass_cnt++;
    op1(4'h5, 4'h3, 1'b1, got, lat);
    total_cnt++;
    if (lat !== 1 || got !== 5'h09) $display("FAIL w1_small got=%0d_%h exp=1_09", lat, got);
    else pass_cnt++;
    for (int t = 0; t < 30; t++) begin
      ra = 4'($urandom);
      rb = 4'($urandom);
      rc = 1'($urandom_range(0, 1));
      exp_r = {1'b0, ra} + {1'b0, rb} + {4'h0, rc};
      op1(ra, rb, rc, got, lat);
      total_cnt++;
      if (lat !== 1 || got !== exp_r) $display("FAIL w1_rand t=%0d got=%0d_%h exp=1_%h", t, lat, got, exp_r);
      else pass_cnt++;
    end
  endtask

  task automatic test_n8();
    int lat;
    logic [24:0] got;
    logic [23:0] ra, rb;
    logic        rc;
    logic [24:0] exp_r;
    op8(24'hFFFFFF, 24'h000001, 1'b0, got, lat);
    total_cnt++;
    if (lat !== 3 || got !== 25'h1000000) $display("FAIL n8_ripple got=%0d_%h exp=3_1000000", lat, got);
    else pass_cnt++;
    op8(24'h123456, 24'hABCDEF, 1'b0, got, lat);
    total_cnt++;
    if (lat !== 3 || got !== 25'h0BE0245) $display("FAIL n8_mixed got=%0d_%h exp=3_0be0245", lat, got);
    else pass_cnt++;
    op8(24'h800000, 24'h800000, 1'b1, got, lat);
    total_cnt++;
    if (lat !== 3 || got !== 25'h1000001) $display("FAIL n8_top got=%0d_%h exp=3_1000001", lat, got);
    else pass_cnt++;
    for (int t = 0; t < 30; t++) begin
      ra = 24'($urandom);
      rb = 24'($urandom);
      rc = 1'($urandom_range(0, 1));
      exp_r = {1'b0, ra} + {1'b0, rb} + {24'h0, rc};
      op8(ra, rb, rc, got, lat);
      total_cnt++;
      if (lat !== 3 || got !== exp_r) $display("FAIL n8_rand t=%0d got=%0d_%h exp=3_%h", t, lat, got, exp_r);
      else pass_cnt++;
    end
  endtask

  initial begin
    rst = 1'b1;
    bus4.in_valid = 1'b0; bus4.out_ready = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0;
    bus1.in_valid = 1'b0; bus1.out_ready = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;
    bus8.in_valid = 1'b0; bus8.out_ready = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
`ifdef MWADD_SUB_EN
    bus4.sub = 1'b0; bus1.sub = 1'b0; bus8.sub = 1'b0;
`endif
    test_reset();
    test_carry_ripple();
    test_backpressure();
    test_busy_rejection();
    test_reset_mid();
`ifdef MWADD_SUB_EN
    test_sub();
`endif
    test_random();
    test_words1();
    test_n8();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
